// File: rtl/dma_mon_pkg.sv
// Shared types and constants for the DMA request/acknowledge protocol monitor.
package dma_mon_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      REQ    = 2'd1,
      ACTIVE = 2'd2
   } monState_e;

   // Bit positions inside err_flags
   localparam int ERR_WRONG_GRANT  = 0;
   localparam int ERR_TIMEOUT      = 1;
   localparam int ERR_MULTI_DACK   = 2;
   localparam int ERR_DACK_NO_HLDA = 3;
   localparam int ERR_AEN          = 4;
   localparam int ERR_ADSTB_WIDTH  = 5;
   localparam int NUM_ERR          = 6;

   // Widest channel vector the monitor supports
   localparam int MAX_CH = 8;

   // True when at most one bit is set (zero counts as legal)
   function automatic logic isOneHot0(input logic [MAX_CH-1:0] v);
      return (v & (v - MAX_CH'(1))) == '0;
   endfunction

endpackage

// File: rtl/dma_prio_resolver.sv
// Find-first over the request vector starting at index top, wrapping around.
module dma_prio_resolver #(
   parameter int NUM_CH = 4
) (
   input  logic [NUM_CH-1:0]         req,
   input  logic [$clog2(NUM_CH)-1:0] top,
   output logic [NUM_CH-1:0]         grant
);
   localparam int PTR_W = $clog2(NUM_CH);

   logic             found;
   logic [PTR_W-1:0] idx;

   // scan NUM_CH positions beginning at top; first set request wins
   always_comb begin
      grant = '0;
      found = 1'b0;
      idx   = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         idx = PTR_W'((int'(top) + i) % NUM_CH);
         if (!found && req[idx]) begin
            grant[idx] = 1'b1;
            found      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/dma_arb_monitor.sv
// Protocol monitor for the DMA DREQ -> HLDA -> DACK handshake: predicts the
// grant under fixed or rotating priority and flags ordering, exclusivity and
// latency violations. Define DMA_MON_COV_EN to add per-channel service counts.
module dma_arb_monitor
   import dma_mon_pkg::*;
#(
   parameter int NUM_CH  = 4,
   parameter int TIMEOUT = 16
) (
   input  logic                 CLK,
   input  logic                 RESET_N,
   input  logic [NUM_CH-1:0]    DREQ,
   input  logic [NUM_CH-1:0]    DACK,
   input  logic                 HRQ,
   input  logic                 HLDA,
   input  logic                 AEN,
   input  logic                 ADSTB,
   input  logic                 rotate_mode,
   input  logic                 err_clear,
   output logic [NUM_CH-1:0]    expected_dack,
   output logic [NUM_ERR-1:0]   err_flags,
   output logic                 err_pulse
`ifdef DMA_MON_COV_EN
   ,output logic [NUM_CH*16-1:0] cov_grant_cnt
`endif
);
   localparam int PTR_W = $clog2(NUM_CH);
   localparam int CNT_W = $clog2(TIMEOUT + 1);

   monState_e        state, stateNxt;
   logic [CNT_W-1:0] cnt, cntNxt;
   logic [NUM_CH-1:0] lastDack, lastNxt, expNxt, grant;
   logic [PTR_W-1:0] top, topNxt, servedIdx;
   logic             hldaSeen, seenNxt, adstbPrev;
   logic             wrongGrant, timeoutErr;
   logic [NUM_ERR-1:0] errSet, flagsKept;

   // HRQ is taken for bus completeness; the hold handshake is judged from HLDA
   logic unusedHrq;
   assign unusedHrq = HRQ;

   dma_prio_resolver #(.NUM_CH(NUM_CH)) uResolver (
      .req   (DREQ),
      .top   (rotate_mode ? top : '0),
      .grant (grant)
   );

   // channel index of the grant being served (lowest bit if several were set)
   always_comb begin
      servedIdx = '0;
      for (int i = NUM_CH - 1; i >= 0; i--)
         if (lastDack[i]) servedIdx = PTR_W'(i);
   end

   // next-state logic for the handshake tracker
   always_comb begin
      stateNxt   = state;
      cntNxt     = cnt;
      expNxt     = expected_dack;
      seenNxt    = hldaSeen;
      lastNxt    = lastDack;
      topNxt     = top;
      wrongGrant = 1'b0;
      timeoutErr = 1'b0;
      case (state)
         IDLE: begin
            cntNxt  = '0;
            seenNxt = 1'b0;
            expNxt  = '0;
            if (|DREQ) stateNxt = REQ;
         end
         REQ: begin
            if (!hldaSeen) begin
               if (HLDA) begin
                  // prediction taken from DREQ as sampled on the HLDA-rise cycle
                  seenNxt = 1'b1;
                  expNxt  = grant;
                  cntNxt  = '0;
                  if (|DACK) begin
                     wrongGrant = (DACK != grant);
                     lastNxt    = DACK;
                     stateNxt   = ACTIVE;
                  end else if (!(|DREQ)) begin
                     expNxt   = '0;
                     stateNxt = IDLE;
                  end
               end else if (!(|DREQ) && !(|DACK)) begin
                  stateNxt = IDLE;
               end
            end else begin
               // cnt == TIMEOUT means TIMEOUT cycles already passed without DACK
               if (|DACK && cnt != CNT_W'(TIMEOUT)) begin
                  wrongGrant = (DACK != expected_dack);
                  lastNxt    = DACK;
                  stateNxt   = ACTIVE;
               end else if (cnt == CNT_W'(TIMEOUT)) begin
                  timeoutErr = 1'b1;
                  expNxt     = '0;
                  stateNxt   = IDLE;
               end else if (!(|DREQ)) begin
                  expNxt   = '0;
                  stateNxt = IDLE;
               end else begin
                  cntNxt = cnt + 1'b1;
               end
            end
         end
         ACTIVE: begin
            if (|DACK) begin
               if (DACK != lastDack) wrongGrant = 1'b1;
               lastNxt = DACK;
            end else begin
               topNxt   = (servedIdx == PTR_W'(NUM_CH - 1)) ? '0 : servedIdx + 1'b1;
               expNxt   = '0;
               lastNxt  = '0;
               stateNxt = IDLE;
            end
         end
         default: stateNxt = IDLE;
      endcase
   end

   // tracker registers; reset abandons any transfer in progress
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state         <= IDLE;
         cnt           <= '0;
         expected_dack <= '0;
         hldaSeen      <= 1'b0;
         lastDack      <= '0;
         top           <= '0;
      end else begin
         state         <= stateNxt;
         cnt           <= cntNxt;
         expected_dack <= expNxt;
         hldaSeen      <= seenNxt;
         lastDack      <= lastNxt;
         top           <= topNxt;
      end
   end

   // violations detected this cycle, independent of tracker state where noted
   always_comb begin
      errSet                   = '0;
      errSet[ERR_WRONG_GRANT]  = wrongGrant;
      errSet[ERR_TIMEOUT]      = timeoutErr;
      errSet[ERR_MULTI_DACK]   = !isOneHot0(MAX_CH'(DACK));
      errSet[ERR_DACK_NO_HLDA] = (|DACK) && !HLDA;
      errSet[ERR_AEN]          = (|DACK) && !AEN;
      errSet[ERR_ADSTB_WIDTH]  = ADSTB && adstbPrev;
   end

   // a violation coinciding with err_clear still sets its flag and pulses
   assign flagsKept = err_clear ? '0 : err_flags;

   // sticky flags, new-flag pulse and strobe history
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         err_flags <= '0;
         err_pulse <= 1'b0;
         adstbPrev <= 1'b0;
      end else begin
         err_flags <= flagsKept | errSet;
         err_pulse <= |(errSet & ~flagsKept);
         adstbPrev <= ADSTB;
      end
   end

`ifdef DMA_MON_COV_EN
   for (genvar g = 0; g < NUM_CH; g++) begin : gCov
      logic [15:0] svcCnt;
      // count completed services of channel g, saturating
      always_ff @(posedge CLK or negedge RESET_N) begin
         if (!RESET_N)
            svcCnt <= '0;
         else if (err_clear)
            svcCnt <= '0;
         else if (state == ACTIVE && !(|DACK) && servedIdx == PTR_W'(g) && svcCnt != 16'hFFFF)
            svcCnt <= svcCnt + 16'd1;
      end
      assign cov_grant_cnt[g*16 +: 16] = svcCnt;
   end
`endif

endmodule
